// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared states, opcodes and widths for the ALU operand loader
package alu_pkg;

  localparam int NIBBLE_W = 4;
  localparam int RESULT_W = 8;

  localparam logic [NIBBLE_W-1:0] OP_NOP = 4'd0;
  localparam logic [NIBBLE_W-1:0] OP_ADD = 4'd1;
  localparam logic [NIBBLE_W-1:0] OP_SUB = 4'd2;
  localparam logic [NIBBLE_W-1:0] OP_AND = 4'd3;
  localparam logic [NIBBLE_W-1:0] OP_OR  = 4'd4;
  localparam logic [NIBBLE_W-1:0] OP_XOR = 4'd5;
  localparam logic [NIBBLE_W-1:0] OP_MUL = 4'd6;
  localparam logic [NIBBLE_W-1:0] OP_SHL = 4'd7;
  localparam logic [NIBBLE_W-1:0] OP_SHR = 4'd8;
  localparam logic [NIBBLE_W-1:0] OP_NOT = 4'd9;
  localparam logic [NIBBLE_W-1:0] OP_EQ  = 4'd10;
  localparam logic [NIBBLE_W-1:0] OP_NE  = 4'd11;
  localparam logic [NIBBLE_W-1:0] OP_GT  = 4'd12;
  localparam logic [NIBBLE_W-1:0] OP_LT  = 4'd13;
  localparam logic [NIBBLE_W-1:0] OP_DIV = 4'd14;

  typedef enum logic [2:0] {
    S_OP   = 3'd0,
    S_A    = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  // The ALU only sees a live opcode while the loader is executing
  function automatic logic is_busy_state(input state_t s);
    return (s == S_EXEC) || (s == S_WAIT);
  endfunction

endpackage

// File: rtl/strobe_sync_edge.sv
// rtl/strobe_sync_edge.sv - pin strobe synchroniser with one-cycle rising-edge pulse
module strobe_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // Shift the async level through the synchroniser and keep one cycle of history
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - nibble-serial opcode/operand loader and result latch for the 4-bit ALU (optional ALU_OPERAND_LOADER_TIMEOUT_EN)
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int RESULT_LATENCY = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NIBBLE_W-1:0] data_in,
  input  logic                load_strobe,
  input  logic [RESULT_W-1:0] alu_result,
  output logic [NIBBLE_W-1:0] op_select,
  output logic [NIBBLE_W-1:0] a,
  output logic [NIBBLE_W-1:0] b,
  output logic [RESULT_W-1:0] result,
  output logic                result_valid,
  output logic                busy,
  output logic                timeout_err
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NIBBLE_W-1:0] r_op;
  logic [NIBBLE_W-1:0] r_a;
  logic [NIBBLE_W-1:0] r_b;
  logic [RESULT_W-1:0] r_result;
  logic                r_result_valid;
  logic [2:0]          r_wait_cnt;
  logic                w_ld;
  logic                w_to_hit;

  strobe_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_strobe (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (load_strobe),
    .o_pulse (w_ld)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state <= S_OP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: strobes outside the load states are ignored
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_OP: begin
        if (w_ld) w_state_nxt = S_A;
      end
      S_A: begin
        if (w_ld)          w_state_nxt = S_B;
        else if (w_to_hit) w_state_nxt = S_OP;
      end
      S_B: begin
        if (w_ld)          w_state_nxt = S_EXEC;
        else if (w_to_hit) w_state_nxt = S_OP;
      end
      S_EXEC: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_wait_cnt == 3'd0) w_state_nxt = S_OP;
      end
      default: begin
        w_state_nxt = S_OP;
      end
    endcase
  end

  // Nibble capture, ALU latency countdown and result latch
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_op           <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_wait_cnt     <= 3'd0;
    end else begin
      case (r_state)
        S_OP: begin
          if (w_ld) begin
            r_op           <= data_in;
            r_result_valid <= 1'b0;
          end
        end
        S_A: begin
          if (w_ld) r_a <= data_in;
        end
        S_B: begin
          if (w_ld) r_b <= data_in;
        end
        S_EXEC: begin
          r_wait_cnt <= 3'(RESULT_LATENCY - 1);
        end
        S_WAIT: begin
          if (r_wait_cnt == 3'd0) begin
            r_result       <= alu_result;
            r_result_valid <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ALU_OPERAND_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout_err;
  logic            w_in_load;

  assign w_in_load = (r_state == S_A) || (r_state == S_B);
  assign w_to_hit  = w_in_load && !w_ld && (r_to_cnt == TO_W'(TIMEOUT_CYCLES));

  // Idle counter between nibbles plus the sticky abandonment flag
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_in_load && !w_ld) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end
      if (w_to_hit) begin
        r_timeout_err <= 1'b1;
      end else if ((r_state == S_OP) && w_ld) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign w_to_hit             = 1'b0;
  assign timeout_err          = 1'b0;
`endif

  assign busy         = is_busy_state(r_state);
  assign op_select    = busy ? r_op : OP_NOP;
  assign a            = r_a;
  assign b            = r_b;
  assign result       = r_result;
  assign result_valid = r_result_valid;

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - scoreboard bench for alu_operand_loader with a registered ALU model
module tb_alu_operand_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] data_in;
  logic       load_strobe;
  logic [7:0] alu_result;
  logic [3:0] op_select;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] result;
  logic       result_valid;
  logic       busy;
  logic       timeout_err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;

  always #5 clk = ~clk;

  alu_operand_loader #(
    .SYNC_STAGES   (2),
    .RESULT_LATENCY(1),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_in     (data_in),
    .load_strobe (load_strobe),
    .alu_result  (alu_result),
    .op_select   (op_select),
    .a           (a),
    .b           (b),
    .result      (result),
    .result_valid(result_valid),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y);
    logic [7:0] xe;
    logic [7:0] ye;
    xe = {4'b0, x};
    ye = {4'b0, y};
    case (op)
      4'd1:    return xe + ye;
      4'd2:    return xe - ye;
      4'd3:    return xe & ye;
      4'd4:    return xe | ye;
      4'd5:    return xe ^ ye;
      4'd6:    return xe * ye;
      4'd10:   return {7'b0, x == y};
      4'd11:   return {7'b0, x != y};
      default: return 8'h00;
    endcase
  endfunction

  // One-cycle registered ALU
  always @(posedge clk) alu_result <= alu_f(op_select, a, b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every fresh result is matched against the oldest expectation
  always @(negedge clk) begin
    if (result_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {24'b0, result}, 32'hFFFF_FFFF);
      end else begin
        chk("result", {24'b0, result}, {24'b0, exp_q.pop_front()});
        chk("op_select_idle", {28'b0, op_select}, 32'h0);
        chk("busy_idle", {31'b0, busy}, 32'h0);
      end
    end
    prev_valid = result_valid;
  end

  task automatic pulse(input logic [3:0] d);
    @(negedge clk);
    data_in     = d;
    load_strobe = 1'b1;
    repeat (3) @(negedge clk);
    load_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic seq(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp);
    exp_q.push_back(exp);
    pulse(op);
    pulse(x);
    pulse(y);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    reset_n     = 1'b1;
    load_strobe = 1'b0;
    data_in     = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_result", {24'b0, result}, 32'h0);
    chk("rst_valid", {31'b0, result_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_op_select", {28'b0, op_select}, 32'h0);
    chk("rst_a", {28'b0, a}, 32'h0);
    chk("rst_b", {28'b0, b}, 32'h0);
    chk("rst_timeout", {31'b0, timeout_err}, 32'h0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);

    seq(4'd1, 4'd3, 4'd2, 8'h05);
    seq(4'd2, 4'd2, 4'd5, 8'hFD);
    seq(4'd6, 4'd7, 4'd7, 8'h31);
    repeat (10) @(negedge clk);
    chk("hold_result", {24'b0, result}, 32'h31);
    chk("hold_valid", {31'b0, result_valid}, 32'h1);

    seq(4'd15, 4'd5, 4'd5, 8'h00);

    // Fourth strobe rises again right after the b strobe so its pulse lands in S_WAIT
    exp_q.push_back(8'h08);
    pulse(4'd1);
    pulse(4'd4);
    @(negedge clk);
    data_in     = 4'd4;
    load_strobe = 1'b1;
    @(negedge clk);
    load_strobe = 1'b0;
    @(negedge clk);
    load_strobe = 1'b1;
    @(negedge clk);
    data_in = 4'd9;
    repeat (3) @(negedge clk);
    load_strobe = 1'b0;
    repeat (5) @(negedge clk);
    chk("drop_busy", {31'b0, busy}, 32'h0);
    chk("drop_valid", {31'b0, result_valid}, 32'h1);
    chk("drop_result", {24'b0, result}, 32'h08);

    pulse(4'd1);
    pulse(4'd3);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_result", {24'b0, result}, 32'h0);
    chk("midrst_valid", {31'b0, result_valid}, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_a", {28'b0, a}, 32'h0);
    reset_n = 1'b0;
    seq(4'd3, 4'hF, 4'd5, 8'h05);
    chk("a_reflect", {28'b0, a}, 32'hF);
    chk("b_reflect", {28'b0, b}, 32'h5);

`ifdef ALU_OPERAND_LOADER_TIMEOUT_EN
    pulse(4'd1);
    repeat (20) @(negedge clk);
    chk("to_err_set", {31'b0, timeout_err}, 32'h1);
    chk("to_busy", {31'b0, busy}, 32'h0);
    seq(4'd10, 4'd4, 4'd4, 8'h01);
    chk("to_err_clr", {31'b0, timeout_err}, 32'h0);
`else
    chk("to_tied_low", {31'b0, timeout_err}, 32'h0);
`endif

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("sb_drain", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
